add_sub_seq: RTL and testbench

Parametrised multi-cycle adder/subtractor, the sequential successor of the team's 4-bit combinational add/sub. It computes `a + b` or `a - b` at `WIDTH` bits, `CHUNK` bits per clock, using one `CHUNK`-bit adder slice and a rippled carry register. It reports carry-out, signed overflow and zero flags. Operands and results move over independent valid/ready handshakes, so the block sits directly on a datapath stream.

---
 rtl/add_sub_if.sv | 27 ++
 rtl/add_sub_seq.sv | 120 ++++++++++++
 tb/tb_add_sub_seq.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_sub_if.sv
// Operand/result stream bundle for add_sub_seq: valid/ready on the operand
// side and on the result side, each independently flow-controlled.
interface add_sub_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/add_sub_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock with a
// rippled carry register, reporting carry-out, signed overflow and zero flags.
module add_sub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic     clk,
    input  logic     rst,
    add_sub_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $fatal(1, "add_sub_seq: illegal WIDTH=%0d CHUNK=%0d", WIDTH, CHUNK);
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, work_q, work_d, sum_q, sum_d;
    logic             sub_q, sub_d, carry_q, carry_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [CHUNK-1:0] a_slice, b_slice;
    logic [CHUNK:0]   slice_sum;
    logic             msb_cin;

    // Single adder slice; B is inverted in subtract mode, the +1 comes from the
    // carry register preloaded with sub at acceptance.
    always_comb begin
        a_slice   = a_q[idx_q*CHUNK +: CHUNK];
        b_slice   = b_q[idx_q*CHUNK +: CHUNK] ^ {CHUNK{sub_q}};
        slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
        msb_cin   = a_slice[CHUNK-1] ^ b_slice[CHUNK-1] ^ slice_sum[CHUNK-1];
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        work_d  = work_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.sub;
                    carry_d = bus.sub;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                work_d[idx_q*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
                carry_d = slice_sum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    sum_d   = work_d;
                    cout_d  = slice_sum[CHUNK];
                    ovf_d   = msb_cin ^ slice_sum[CHUNK];
                    zero_d  = (work_d == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            work_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_add_sub_seq.sv
// Self-checking bench for add_sub_seq: directed and random traffic on a 16/4
// instance plus a parameter sweep, all compared against an arithmetic model.
module tb_add_sub_seq;
    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct packed {
        res_t r;
        int   acc;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   sw_done_cnt = 0;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_sw = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain modular arithmetic; overflow from operand/result signs.
    function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic s);
        longint unsigned mask, av, bv, full;
        logic            sa, sb, ss;
        res_t            r;
        mask   = (64'd1 << w) - 64'd1;
        av     = 64'(a) & mask;
        bv     = 64'(s ? ~b : b) & mask;
        full   = av + bv + 64'(s);
        r.sum  = 16'(full & mask);
        r.cout = ((full >> w) & 64'd1) != 0;
        sa     = ((av >> (w - 1)) & 64'd1) != 0;
        sb     = ((bv >> (w - 1)) & 64'd1) != 0;
        ss     = (((full & mask) >> (w - 1)) & 64'd1) != 0;
        r.ovf  = (sa == sb) && (ss != sa);
        r.zero = (r.sum == 16'h0);
        return r;
    endfunction

    // ---------------- main 16/4 instance ----------------
    add_sub_if #(.WIDTH(16)) bus_m ();
    add_sub_seq #(.WIDTH(16), .CHUNK(4)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));

    exp_t q_m[$];
    int   rc_m[$];
    logic ov_prev_m = 1'b0;
    res_t held_m;
    int   hs_m = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q_m.delete();
            ov_prev_m = 1'b0;
        end else begin
            check("m_excl", 32'(bus_m.in_ready & bus_m.out_valid), 32'd0);
            if (bus_m.in_valid && bus_m.in_ready)
                q_m.push_back('{r: model(16, bus_m.a, bus_m.b, bus_m.sub), acc: cyc + 1});
            if (bus_m.out_valid && !ov_prev_m) begin
                if (q_m.size() == 0) begin
                    check("m_unexpected_result", 32'(q_m.size()), 32'd1);
                end else begin
                    e = q_m.pop_front();
                    check("m_sum", 32'(bus_m.sum), 32'(e.r.sum));
                    check("m_cout", 32'(bus_m.cout), 32'(e.r.cout));
                    check("m_ovf", 32'(bus_m.ovf), 32'(e.r.ovf));
                    check("m_zero", 32'(bus_m.zero), 32'(e.r.zero));
                    check("m_latency", 32'(cyc - e.acc), 32'd4);
                    held_m = e.r;
                    rc_m.push_back(cyc);
                end
            end else if (bus_m.out_valid) begin
                check("m_hold", 32'({bus_m.sum, bus_m.cout, bus_m.ovf, bus_m.zero}), 32'(held_m));
            end
            if (bus_m.out_valid && bus_m.out_ready) hs_m++;
            ov_prev_m = bus_m.out_valid;
        end
    end

    task automatic m_start(input logic [15:0] a, input logic [15:0] b, input logic s);
        int n = 0;
        @(posedge clk); #1;
        bus_m.a = a; bus_m.b = b; bus_m.sub = s; bus_m.in_valid = 1'b1;
        @(negedge clk);
        while (!bus_m.in_ready && n < 50) begin @(negedge clk); n++; end
        check("m_accept", 32'(bus_m.in_ready), 32'd1);
        @(posedge clk); #1;
        bus_m.in_valid = 1'b0;
    endtask

    task automatic m_wait_out(input int bound);
        int n = 0;
        @(negedge clk);
        while (!bus_m.out_valid && n < bound) begin @(negedge clk); n++; end
        check("m_out_valid_seen", 32'(bus_m.out_valid), 32'd1);
    endtask

    // ---------------- parameter sweep ----------------
    logic [3:0] leg_a [4] = '{4'h9, 4'h0, 4'h3, 4'hC};
    logic [3:0] leg_b [4] = '{4'h2, 4'h4, 4'h1, 4'h6};
    logic       leg_s [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    function automatic int sw_w(input int i);
        case (i) 0: return 4; 1: return 8; 2: return 8; default: return 12; endcase
    endfunction
    function automatic int sw_c(input int i);
        case (i) 0: return 4; 1: return 1; 2: return 8; default: return 3; endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int W = sw_w(g);
        localparam int C = sw_c(g);
        localparam int N = W / C;

        add_sub_if #(.WIDTH(W)) bus ();
        add_sub_seq #(.WIDTH(W), .CHUNK(C)) dut (.clk(clk), .rst(rst_sw), .bus(bus));

        exp_t q[$];
        logic ov_prev = 1'b0;
        res_t held;
        int   nres = 0;

        always @(negedge clk) begin
            exp_t e;
            if (!rst_sw) begin
                check($sformatf("sw%0d_excl", g), 32'(bus.in_ready & bus.out_valid), 32'd0);
                if (bus.in_valid && bus.in_ready)
                    q.push_back('{r: model(W, 16'(bus.a), 16'(bus.b), bus.sub), acc: cyc + 1});
                if (bus.out_valid && !ov_prev) begin
                    if (q.size() == 0) begin
                        check($sformatf("sw%0d_unexpected", g), 32'(q.size()), 32'd1);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("sw%0d_sum", g), 32'(bus.sum), 32'(e.r.sum));
                        check($sformatf("sw%0d_flags", g), 32'({bus.cout, bus.ovf, bus.zero}),
                              32'({e.r.cout, e.r.ovf, e.r.zero}));
                        check($sformatf("sw%0d_latency", g), 32'(cyc - e.acc), 32'(N));
                        held = e.r;
                        nres++;
                    end
                end else if (bus.out_valid) begin
                    check($sformatf("sw%0d_hold", g), 32'({16'(bus.sum), bus.cout, bus.ovf, bus.zero}),
                          32'(held));
                end
                ov_prev = bus.out_valid;
            end
        end

        always @(posedge clk) #1 bus.out_ready = ($urandom_range(0, 2) != 0);

        initial begin
            bus.in_valid = 1'b0;
            bus.a = '0;
            bus.b = '0;
            bus.sub = 1'b0;
            wait (!rst_sw);
            for (int k = 0; k < 24; k++) begin
                int n = 0;
                @(posedge clk); #1;
                if (k < 4) begin
                    bus.a = W'(leg_a[k]); bus.b = W'(leg_b[k]); bus.sub = leg_s[k];
                end else begin
                    bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = 1'($urandom);
                end
                bus.in_valid = 1'b1;
                @(negedge clk);
                while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                n = 0;
                while (nres < k + 1 && n < 100) begin @(negedge clk); n++; end
            end
            check($sformatf("sw%0d_count", g), 32'(nres), 32'd24);
            sw_done_cnt++;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int   n;
        res_t snap;
        int   hs0;
        int   acc;

        bus_m.in_valid = 1'b0;
        bus_m.a = '0;
        bus_m.b = '0;
        bus_m.sub = 1'b0;
        bus_m.out_ready = 1'b1;

        // Hand-computed expectations pinning the model.
        check("pin_leg0", 32'(model(4, 16'h9, 16'h2, 1'b0)), 32'({16'h000B, 3'b000}));
        check("pin_leg1", 32'(model(4, 16'h0, 16'h4, 1'b1)), 32'({16'h000C, 3'b000}));
        check("pin_leg2", 32'(model(4, 16'h3, 16'h1, 1'b1)), 32'({16'h0002, 3'b100}));
        check("pin_leg3", 32'(model(4, 16'hC, 16'h6, 1'b1)), 32'({16'h0006, 3'b110}));
        check("pin_f0", 32'(model(16, 16'h7FFF, 16'h0001, 1'b0)), 32'({16'h8000, 3'b010}));
        check("pin_f1", 32'(model(16, 16'hFFFF, 16'h0001, 1'b0)), 32'({16'h0000, 3'b101}));
        check("pin_f2", 32'(model(16, 16'h8000, 16'h0001, 1'b1)), 32'({16'h7FFF, 3'b110}));
        check("pin_f3", 32'(model(16, 16'h0000, 16'h0001, 1'b1)), 32'({16'hFFFF, 3'b000}));
        check("pin_f4", 32'(model(16, 16'h1234, 16'h1234, 1'b1)), 32'({16'h0000, 3'b101}));

        #7;
        check("rst_in_ready", 32'(bus_m.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus_m.out_valid), 32'd0);
        check("rst_results", 32'({bus_m.sum, bus_m.cout, bus_m.ovf, bus_m.zero}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rst_sw = 1'b0;

        // Flag vectors.
        m_start(16'h7FFF, 16'h0001, 1'b0); m_wait_out(10);
        m_start(16'hFFFF, 16'h0001, 1'b0); m_wait_out(10);
        m_start(16'h8000, 16'h0001, 1'b1); m_wait_out(10);
        m_start(16'h0000, 16'h0001, 1'b1); m_wait_out(10);
        m_start(16'h1234, 16'h1234, 1'b1); m_wait_out(10);

        // Reset one cycle into RUN.
        m_start(16'h1111, 16'h2222, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(bus_m.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus_m.out_valid), 32'd0);
        check("mid_rst_results", 32'({bus_m.sum, bus_m.cout, bus_m.ovf, bus_m.zero}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mid_rst_no_result", 32'(bus_m.out_valid), 32'd0);
        end
        m_start(16'h0003, 16'h0004, 1'b0);
        m_wait_out(10);
        check("after_rst_sum", 32'(bus_m.sum), 32'h0007);

        // Backpressure with input activity in DONE.
        @(posedge clk); #1;
        bus_m.out_ready = 1'b0;
        m_start(16'hABCD, 16'h1357, 1'b1);
        m_wait_out(10);
        snap = '{sum: bus_m.sum, cout: bus_m.cout, ovf: bus_m.ovf, zero: bus_m.zero};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus_m.a = 16'($urandom);
            bus_m.b = 16'($urandom);
            bus_m.in_valid = 1'($urandom);
            @(negedge clk);
            check("bp_in_ready", 32'(bus_m.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus_m.out_valid), 32'd1);
            check("bp_stable", 32'({bus_m.sum, bus_m.cout, bus_m.ovf, bus_m.zero}), 32'(snap));
        end
        @(posedge clk); #1;
        bus_m.in_valid = 1'b0;
        bus_m.out_ready = 1'b1;
        hs0 = hs_m;
        @(posedge clk); #1;
        check("bp_release_out_valid", 32'(bus_m.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus_m.in_ready), 32'd1);
        repeat (3) @(posedge clk);
        check("bp_one_handshake", 32'(hs_m - hs0), 32'd1);

        // Streaming with in_valid and out_ready held high.
        rc_m.delete();
        acc = 0;
        n = 0;
        @(posedge clk); #1;
        bus_m.a = 16'($urandom); bus_m.b = 16'($urandom); bus_m.sub = 1'($urandom);
        bus_m.in_valid = 1'b1;
        while (rc_m.size() < 10 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus_m.in_ready && bus_m.in_valid) begin
                acc++;
                @(posedge clk); #1;
                if (acc < 10) begin
                    bus_m.a = 16'($urandom); bus_m.b = 16'($urandom); bus_m.sub = 1'($urandom);
                end else begin
                    bus_m.in_valid = 1'b0;
                end
            end
        end
        check("stream_count", 32'(rc_m.size()), 32'd10);
        for (int i = 1; i < rc_m.size(); i++)
            check("stream_spacing", 32'(rc_m[i] - rc_m[i-1]), 32'd6);

        n = 0;
        while (sw_done_cnt < 4 && n < 20000) begin @(posedge clk); n++; end
        check("sweep_done", 32'(sw_done_cnt), 32'd4);
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
